// File: rtl/miner_pkg.sv
// miner_pkg -- shared definitions for the miner job controller.
//   JOB_BYTES / field offsets : layout of the 80-byte big-endian job stream
//   state_t                   : controller states
//   LED_*                     : bit positions on the 8-bit board LED port
//   nonce_offset()            : per-core offset into the 32-bit nonce space
package miner_pkg;

    localparam int JOB_BYTES = 80;
    localparam int JOB_BITS  = JOB_BYTES * 8;

    // Byte offsets of each field within the job stream.
    localparam int OFS_DIGEST_INITIAL = 0;
    localparam int OFS_DIGEST_MID     = 32;
    localparam int OFS_MERKLE         = 64;
    localparam int OFS_TIME           = 68;
    localparam int OFS_TARGET         = 72;
    localparam int OFS_NONCE_BASE     = 76;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DISPATCH,
        RUN,
        REPORT
    } state_t;

    localparam int LED_HEARTBEAT = 0;
    localparam int LED_LOAD      = 1;
    localparam int LED_BUSY      = 2;
    localparam int LED_FOUND     = 3;
    localparam int LED_EXHAUSTED = 4;
    localparam int LED_CORE_LSB  = 5;

    // idx * 2^(32 - core_bits) mod 2^32. Computed wide so a single core
    // (core_bits = 0) cleanly yields a zero offset instead of a 32-bit shift.
    function automatic logic [31:0] nonce_offset(input int unsigned idx,
                                                 input int unsigned core_bits);
        logic [63:0] wide;
        wide = 64'(idx) << (32 - core_bits);
        return wide[31:0];
    endfunction

endpackage

// File: rtl/job_loader.sv
// job_loader -- 80-byte job shift register with byte counter.
//   clk, rst_n       : clock, async active-low reset
//   byte_data        : incoming job byte
//   byte_accept      : byte_data is consumed this cycle
//   load_done        : combinational pulse while the 80th byte is accepted
//   digest_initial.. : job fields decoded from the register
//   nonce_base_next  : nonce_base as it will read after this cycle's shift
module job_loader
    import miner_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   byte_data,
    input  logic         byte_accept,
    output logic         load_done,
    output logic [255:0] digest_initial,
    output logic [255:0] digest_mid,
    output logic [31:0]  merkle,
    output logic [31:0]  time_val,
    output logic [31:0]  target,
    output logic [31:0]  nonce_base_next
);

    localparam int DI_MSB = JOB_BITS - 1 - 8 * OFS_DIGEST_INITIAL;
    localparam int DM_MSB = JOB_BITS - 1 - 8 * OFS_DIGEST_MID;
    localparam int MK_MSB = JOB_BITS - 1 - 8 * OFS_MERKLE;
    localparam int TM_MSB = JOB_BITS - 1 - 8 * OFS_TIME;
    localparam int TG_MSB = JOB_BITS - 1 - 8 * OFS_TARGET;

    logic [JOB_BITS-1:0] shift_q;
    logic [6:0]          count_q;

    // Bytes arrive big-endian, so shifting in at the LSB leaves byte 0 at the
    // top once all 80 are in. The counter returns to 0 after every job, so a
    // new job always starts from byte 0 without an explicit clear.
    // NOTE: the job register is reset even though it is wide: the job fields
    // are outputs and must read 0 out of reset. Sequential state uses <= so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (byte_accept) begin
            shift_q <= {shift_q[JOB_BITS-9:0], byte_data};
            count_q <= (count_q == 7'(JOB_BYTES - 1)) ? 7'd0 : count_q + 7'd1;
        end
    end

    assign load_done       = byte_accept && (count_q == 7'(JOB_BYTES - 1));
    assign nonce_base_next = {shift_q[23:0], byte_data};

    assign digest_initial = shift_q[DI_MSB -: 256];
    assign digest_mid     = shift_q[DM_MSB -: 256];
    assign merkle         = shift_q[MK_MSB -: 32];
    assign time_val       = shift_q[TM_MSB -: 32];
    assign target         = shift_q[TG_MSB -: 32];

endmodule

// File: rtl/miner_job_ctrl.sv
// miner_job_ctrl -- job controller for the SHA-256 miner.
// Loads an 80-byte job from a byte stream, splits the nonce space across
// NUM_CORES hashers, collects the first winning nonce and drives status LEDs.
//   clk, rst_n                : clock, async active-low reset
//   rx_data/rx_valid/rx_ready : job byte stream
//   digest_initial..target    : job words for the cores
//   core_nonce_start          : per-core start nonce, core i at [32i+31:32i]
//   core_start / core_abort   : one-cycle pulses to all cores
//   core_valid/core_nonce     : per-core solution report
//   core_done                 : per-core range exhausted (level)
//   result_*                  : valid/ready winning-nonce port
//   led                       : heartbeat, load, busy, found, exhausted, winner
module miner_job_ctrl
    import miner_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int HB_W      = 26
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [255:0]           digest_initial,
    output logic [255:0]           digest_mid,
    output logic [31:0]            merkle,
    output logic [31:0]            time_val,
    output logic [31:0]            target,
    output logic [32*NUM_CORES-1:0] core_nonce_start,
    output logic [NUM_CORES-1:0]   core_start,
    output logic [NUM_CORES-1:0]   core_abort,
    input  logic [NUM_CORES-1:0]   core_valid,
    input  logic [32*NUM_CORES-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]   core_done,
    output logic                   result_valid,
    output logic [31:0]            result_nonce,
    output logic [2:0]             result_core,
    input  logic                   result_ready,
    output logic [7:0]             led
);

    localparam int CORE_BITS = $clog2(NUM_CORES);

    state_t state_q, state_d;

    logic            rx_en_q;
    logic            accept;
    logic            any_valid;
    logic            all_done;
    logic            load_done;
    logic [31:0]     nonce_base_next;
    logic [2:0]      win_idx;
    logic [31:0]     win_nonce;
    logic            start_d;
    logic            abort_d;
    logic            capture;
    logic            set_exhausted;
    logic            new_job;
    logic            found_q;
    logic            exhausted_q;
    logic [HB_W-1:0] hb_q;

    assign any_valid = |core_valid;
    assign all_done  = &core_done;

    // rx_ready is low for the first cycle after reset and in DISPATCH/REPORT.
    // In RUN it drops as soon as a winner (or exhaustion) is visible so a
    // simultaneous byte is held off instead of being half-consumed; it is then
    // taken normally once the controller is back in IDLE.
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        rx_ready = 1'b0;
        if (rx_en_q) begin
            case (state_q)
                IDLE, LOAD: rx_ready = 1'b1;
                RUN:        rx_ready = !any_valid && !all_done;
                default:    rx_ready = 1'b0;
            endcase
        end
    end

    assign accept = rx_valid && rx_ready;

    job_loader u_job_loader (
        .clk             (clk),
        .rst_n           (rst_n),
        .byte_data       (rx_data),
        .byte_accept     (accept),
        .load_done       (load_done),
        .digest_initial  (digest_initial),
        .digest_mid      (digest_mid),
        .merkle          (merkle),
        .time_val        (time_val),
        .target          (target),
        .nonce_base_next (nonce_base_next)
    );

    // Lowest-index winner: scanning downwards lets the lowest set bit win.
    always_comb begin
        win_idx   = '0;
        win_nonce = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_valid[i]) begin
                win_idx   = 3'(i);
                win_nonce = core_nonce[32*i +: 32];
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = LOAD;
            LOAD:     if (load_done) state_d = DISPATCH;
            DISPATCH: state_d = RUN;
            RUN: begin
                if (any_valid)     state_d = REPORT;
                else if (all_done) state_d = IDLE;
                else if (accept)   state_d = LOAD;
            end
            REPORT:   if (result_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (next values of registered outputs) ----
    always_comb begin
        start_d       = (state_q == LOAD) && (state_d == DISPATCH);
        abort_d       = (state_q == RUN) && (any_valid || accept);
        capture       = (state_q == RUN) && any_valid;
        set_exhausted = (state_q == RUN) && !any_valid && all_done;
        new_job       = accept && ((state_q == IDLE) || (state_q == RUN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_en_q          <= 1'b0;
            core_start       <= '0;
            core_abort       <= '0;
            core_nonce_start <= '0;
            result_valid     <= 1'b0;
            result_nonce     <= '0;
            result_core      <= '0;
            found_q          <= 1'b0;
            exhausted_q      <= 1'b0;
            hb_q             <= '0;
        end else begin
            rx_en_q      <= 1'b1;
            hb_q         <= hb_q + 1'b1;
            core_start   <= {NUM_CORES{start_d}};
            core_abort   <= {NUM_CORES{abort_d}};
            result_valid <= (state_d == REPORT);

            // Start nonces are taken from the value completing this cycle so
            // they are already valid alongside the core_start pulse.
            if (load_done) begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    core_nonce_start[32*i +: 32] <=
                        nonce_base_next + nonce_offset(i, CORE_BITS);
                end
            end

            if (capture) begin
                result_nonce <= win_nonce;
                result_core  <= win_idx;
            end

            if (capture)      found_q <= 1'b1;
            else if (new_job) found_q <= 1'b0;

            if (set_exhausted) exhausted_q <= 1'b1;
            else if (new_job)  exhausted_q <= 1'b0;
        end
    end

    always_comb begin
        led                   = '0;
        led[LED_HEARTBEAT]    = hb_q[HB_W-1];
        led[LED_LOAD]         = (state_q == LOAD);
        led[LED_BUSY]         = (state_q == DISPATCH) || (state_q == RUN);
        led[LED_FOUND]        = found_q;
        led[LED_EXHAUSTED]    = exhausted_q;
        led[LED_CORE_LSB +: 3] = result_core;
    end

endmodule

// File: tb/tb_miner_job_ctrl.sv
module tb_miner_job_ctrl;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     rx_data = '0;
    logic           rx_valid = 1'b0;
    logic           rx_ready;
    logic [255:0]   digest_initial, digest_mid;
    logic [31:0]    merkle, time_val, target;
    logic [32*N-1:0] core_nonce_start;
    logic [N-1:0]   core_start, core_abort;
    logic [N-1:0]   core_valid = '0;
    logic [32*N-1:0] core_nonce = '0;
    logic [N-1:0]   core_done = '0;
    logic           result_valid;
    logic [31:0]    result_nonce;
    logic [2:0]     result_core;
    logic           result_ready = 1'b0;
    logic [7:0]     led;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    miner_job_ctrl #(.NUM_CORES(N), .HB_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .digest_initial   (digest_initial),
        .digest_mid       (digest_mid),
        .merkle           (merkle),
        .time_val         (time_val),
        .target           (target),
        .core_nonce_start (core_nonce_start),
        .core_start       (core_start),
        .core_abort       (core_abort),
        .core_valid       (core_valid),
        .core_nonce       (core_nonce),
        .core_done        (core_done),
        .result_valid     (result_valid),
        .result_nonce     (result_nonce),
        .result_core      (result_core),
        .result_ready     (result_ready),
        .led              (led)
    );

    localparam logic [639:0] JOB1 = {
        256'hF59007B5_11223344_55667788_99AABBCC_DDEEFF00_01234567_89ABCDEF_3BC75771,
        256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19,
        32'h252DB801, 32'h130DAE51, 32'h6461011A, 32'h00000000};
    localparam logic [639:0] JOB2 = {
        256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888,
        256'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE_FFFFFFFF_00000001,
        32'hCAFEBABE, 32'h0BADF00D, 32'h1D00FFFF, 32'hF0000000};
    localparam logic [639:0] JOB3 = {
        256'h3C3C3C3C_01010101_02020202_03030303_04040404_05050505_06060606_07070707,
        256'h80808080_90909090_A0A0A0A0_B0B0B0B0_C0C0C0C0_D0D0D0D0_E0E0E0E0_F0F0F0F0,
        32'h13579BDF, 32'h2468ACE0, 32'h0F0F0F0F, 32'h12345678};
    localparam logic [639:0] JOB4 = {
        256'hA5112233_44556677_8899AABB_CCDDEEFF_00112233_44556677_8899AABB_CCDDEEFF,
        256'hFEDCBA98_76543210_FEDCBA98_76543210_FEDCBA98_76543210_FEDCBA98_76543210,
        32'h0000BEEF, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h00000003};

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input logic [639:0] j, input int first, input int last);
        for (int k = first; k <= last; k++) send_byte(j[639-8*k -: 8]);
    endtask

    // Called in the DISPATCH cycle, one cycle after byte 79 was accepted.
    task automatic check_job(input string name, input logic [639:0] j);
        check({name, "_digest_initial"}, digest_initial, j[639:384]);
        check({name, "_digest_mid"}, digest_mid, j[383:128]);
        check({name, "_merkle"}, merkle, j[127:96]);
        check({name, "_time_val"}, time_val, j[95:64]);
        check({name, "_target"}, target, j[63:32]);
        check({name, "_core_start"}, core_start, 4'b1111);
    endtask

    initial begin
        // ---------------- reset ----------------
        step();
        step();
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_digest", digest_initial, 256'h0);
        check("rst_nonce_start", core_nonce_start, 128'h0);
        check("rst_led", led, 8'h00);
        check("rst_result_valid", result_valid, 1'b0);
        check("rst_core_start", core_start, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rx_ready_after_release", rx_ready, 1'b1);
        for (int k = 0; k < 7; k++) step();
        check("heartbeat_on", led[0], 1'b1);

        // ---------------- load and dispatch ----------------
        send_range(JOB1, 0, 39);
        check("load_led", led[1], 1'b1);
        check("load_no_start", core_start, 4'h0);
        send_range(JOB1, 40, 79);
        check_job("job1", JOB1);
        check("job1_nonce_starts", core_nonce_start,
              {32'hC0000000, 32'h80000000, 32'h40000000, 32'h00000000});
        check("job1_busy_led", led[2], 1'b1);
        step();
        check("job1_start_one_cycle", core_start, 4'h0);
        check("job1_run_busy", led[2], 1'b1);

        // ---------------- simultaneous winners + byte ----------------
        core_valid = 4'b1010;
        core_nonce = {32'hDEADBEEF, 32'h00000000, 32'h4A1B2C3D, 32'h00000000};
        rx_data    = 8'h77;
        rx_valid   = 1'b1;
        #1;
        check("win_rx_ready_gated", rx_ready, 1'b0);
        step();
        core_valid = '0;
        rx_valid   = 1'b0;
        check("win_result_valid", result_valid, 1'b1);
        check("win_abort", core_abort, 4'b1111);
        check("win_result_core", result_core, 3'd1);
        check("win_result_nonce", result_nonce, 32'h4A1B2C3D);
        check("win_led_core", led[7:5], 3'b001);
        check("win_led_found", led[3], 1'b1);
        check("win_rx_ready_report", rx_ready, 1'b0);
        step();
        check("win_abort_low", core_abort, 4'h0);
        for (int k = 0; k < 10; k++) begin
            step();
            check("hold_valid", result_valid, 1'b1);
            check("hold_nonce", result_nonce, 32'h4A1B2C3D);
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check("ack_result_valid", result_valid, 1'b0);
        check("ack_rx_ready", rx_ready, 1'b1);
        check("ack_idle_leds", led[2:1], 2'b00);
        check("ack_found_sticky", led[3], 1'b1);

        // ---------------- nonce wrap + exhaustion ----------------
        send_byte(JOB2[639:632]);
        check("job2_first_byte_clears_found", led[3], 1'b0);
        send_range(JOB2, 1, 79);
        check_job("job2", JOB2);
        check("wrap_core1", core_nonce_start[63:32], 32'h30000000);
        check("wrap_core3", core_nonce_start[127:96], 32'hB0000000);
        check("wrap_all", core_nonce_start,
              {32'hB0000000, 32'h70000000, 32'h30000000, 32'hF0000000});
        step();
        core_done = 4'b1111;
        step();
        core_done = '0;
        check("exh_led", led[4], 1'b1);
        check("exh_idle", led[2:1], 2'b00);
        check("exh_result_valid", result_valid, 1'b0);
        check("exh_no_abort", core_abort, 4'h0);
        check("exh_rx_ready", rx_ready, 1'b1);
        step();
        check("exh_stays_idle", led[2:0] & 3'b110, 3'b000);

        // ---------------- new job clears exhausted ----------------
        send_byte(JOB3[639:632]);
        check("job3_clears_exh", led[4], 1'b0);
        check("job3_loading", led[1], 1'b1);
        send_range(JOB3, 1, 79);
        check_job("job3", JOB3);
        check("job3_core0", core_nonce_start[31:0], 32'h12345678);
        check("job3_core2", core_nonce_start[95:64], 32'h92345678);
        step();

        // ---------------- abort by new byte ----------------
        send_byte(8'hA5);
        check("abort_pulse", core_abort, 4'b1111);
        check("abort_to_load", led[2:1], 2'b01);
        check("abort_result_valid", result_valid, 1'b0);
        step();
        check("abort_pulse_end", core_abort, 4'h0);
        send_range(JOB4, 1, 79);
        check_job("job4", JOB4);
        check("job4_first_byte", digest_initial[255:248], 8'hA5);
        check("job4_core3", core_nonce_start[127:96], 32'hC0000003);
        step();

        // ---------------- reset mid-load ----------------
        send_range(JOB3, 0, 40);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_digest", digest_initial, 256'h0);
        check("mid_rst_mid", digest_mid, 256'h0);
        check("mid_rst_target", target, 32'h0);
        check("mid_rst_nonce_start", core_nonce_start, 128'h0);
        check("mid_rst_rx_ready", rx_ready, 1'b0);
        check("mid_rst_led", led, 8'h00);
        check("mid_rst_result", {result_valid, result_nonce, result_core}, 36'h0);
        check("mid_rst_pulses", {core_start, core_abort}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send_range(JOB1, 0, 79);
        check_job("reload", JOB1);
        check("reload_nonce_starts", core_nonce_start,
              {32'hC0000000, 32'h80000000, 32'h40000000, 32'h00000000});
        step();
        check("reload_run", led[2:1], 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
